// File: rtl/ofdm_symbol_sequencer_if.sv
`timescale 1ns/1ps
// ofdm_symbol_sequencer_if
//   Bundles the two streaming links of the OFDM symbol sequencer.
//   s_*    : data-subcarrier input stream (valid/ready), 16-bit signed I/Q.
//   ifft_* : 64-bin output stream into the IFFT (valid/ready), plus ifft_last
//            that marks bin 63 of every symbol.
//   master : the sequencer side (consumes s_*, produces ifft_*).
//   slave  : the environment side (produces s_*, consumes ifft_*).
interface ofdm_symbol_sequencer_if;
   logic signed [15:0] s_re;
   logic signed [15:0] s_im;
   logic               s_valid;
   logic               s_ready;
   logic signed [15:0] ifft_re;
   logic signed [15:0] ifft_im;
   logic               ifft_valid;
   logic               ifft_ready;
   logic               ifft_last;

   modport master (
      input  s_re, s_im, s_valid, ifft_ready,
      output s_ready, ifft_re, ifft_im, ifft_valid, ifft_last
   );

   modport slave (
      output s_re, s_im, s_valid, ifft_ready,
      input  s_ready, ifft_re, ifft_im, ifft_valid, ifft_last
   );
endinterface

// File: rtl/ofdm_symbol_sequencer.sv
`timescale 1ns/1ps
// ofdm_symbol_sequencer
//   Turns a stream of data subcarriers (48 per symbol) into 64-bin OFDM
//   symbols in natural bin order, inserting DC/guard nulls and scrambled
//   pilots in the 802.11a layout, for a programmed number of symbols.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     frame_start  : pulse to begin a frame (ignored while busy)
//     frame_len    : symbols in the frame, sampled with an accepted frame_start
//     busy         : frame in progress
//     frame_done   : pulse the cycle after the final bin is taken by the IFFT
//     io (master)  : s_* data input stream, ifft_* output stream
module ofdm_symbol_sequencer #(
   parameter logic signed [15:0] PILOT_AMP = 16'sd8192,
   parameter int                 LEN_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_start,
   input  logic [LEN_W-1:0]     frame_len,
   output logic                 busy,
   output logic                 frame_done,
   ofdm_symbol_sequencer_if.master io
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [5:0]         bin_cnt;
   logic [LEN_W-1:0]   sym_cnt;
   logic [6:0]         lfsr;

   logic               pol_b;
   logic               bin_null, bin_pilot, bin_data;
   logic               out_free, all_loaded, gate;
   logic               load, s_ready_c, last_hs;
   logic               start_ok, start_nil;
   logic signed [15:0] bin_re, bin_im;

   logic signed [15:0] ifft_re_q, ifft_im_q;
   logic               ifft_valid_q, ifft_last_q, frame_done_q;

   // Pilot polarity bit for the current symbol
   assign pol_b = lfsr[6] ^ lfsr[3];

   // Bin classification
   always_comb begin
      bin_null  = (bin_cnt == 6'd0) || ((bin_cnt >= 6'd27) && (bin_cnt <= 6'd37));
      bin_pilot = (bin_cnt == 6'd7) || (bin_cnt == 6'd21) ||
                  (bin_cnt == 6'd43) || (bin_cnt == 6'd57);
      bin_data  = !bin_null && !bin_pilot;
   end

   // Value presented to the output register for the current bin
   always_comb begin
      bin_re = 16'sd0;
      bin_im = 16'sd0;
      if (bin_data) begin
         bin_re = io.s_re;
         bin_im = io.s_im;
      end else if (bin_pilot) begin
         // Bin 21 carries the inverted pilot; polarity flips the whole set
         bin_re = ((bin_cnt == 6'd21) ^ pol_b) ? -PILOT_AMP : PILOT_AMP;
      end
   end

   assign out_free   = !ifft_valid_q || io.ifft_ready;
   // sym_cnt reaches zero only after the final bin 63 is loaded, which
   // freezes loading while that last bin drains to the IFFT
   assign all_loaded = (sym_cnt == '0);
   assign start_ok   = (state == IDLE) && frame_start && (frame_len != '0);
   assign start_nil  = (state == IDLE) && frame_start && (frame_len == '0);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = RUN;
         RUN:     if (last_hs)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy      = (state == RUN);
      gate      = (state == RUN) && !all_loaded && out_free;
      s_ready_c = gate && bin_data;
      load      = gate && (!bin_data || io.s_valid);
      last_hs   = (state == RUN) && all_loaded && ifft_valid_q && io.ifft_ready;
   end

   // Counters, scrambler and the output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_cnt      <= '0;
         sym_cnt      <= '0;
         lfsr         <= 7'h7F;
         ifft_re_q    <= '0;
         ifft_im_q    <= '0;
         ifft_valid_q <= 1'b0;
         ifft_last_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= start_nil || last_hs;

         if (start_ok) begin
            sym_cnt <= frame_len;
            bin_cnt <= '0;
            lfsr    <= 7'h7F;
         end else if (load) begin
            bin_cnt <= bin_cnt + 6'd1;
            // Stepping the scrambler when bin 63 is loaded is equivalent to
            // stepping it on acceptance: bin 0 of the next symbol cannot load
            // before bin 63 leaves, and the first pilot is bin 7.
            if (bin_cnt == 6'd63) begin
               sym_cnt <= sym_cnt - LEN_W'(1);
               lfsr    <= {lfsr[5:0], pol_b};
            end
         end

         if (load) begin
            ifft_re_q    <= bin_re;
            ifft_im_q    <= bin_im;
            ifft_last_q  <= (bin_cnt == 6'd63);
            ifft_valid_q <= 1'b1;
         end else if (io.ifft_ready) begin
            ifft_valid_q <= 1'b0;
         end
      end
   end

   assign io.s_ready    = s_ready_c;
   assign io.ifft_re    = ifft_re_q;
   assign io.ifft_im    = ifft_im_q;
   assign io.ifft_valid = ifft_valid_q;
   assign io.ifft_last  = ifft_last_q;
   assign frame_done    = frame_done_q;

endmodule

// File: doc/ofdm_symbol_sequencer.md
Name: ofdm_symbol_sequencer

Overview:
- Sequences frequency-domain OFDM symbols into the 64-point IFFT datapath.
- Accepts a stream of data subcarriers (48 per symbol) and emits each symbol as 64 bins in natural order 0..63.
- Inserts DC/guard nulls and polarity-scrambled pilots (802.11a layout).
- Runs a programmed number of symbols per frame, honouring IFFT backpressure.

Parameters:
- PILOT_AMP, 16'sd8192, signed magnitude of pilot real part (Q1.15)
- LEN_W, 8, width of frame length field

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- frame_start  input  1  one-cycle pulse: begin frame, ignored while busy
- frame_len  input  LEN_W  number of symbols in frame, sampled on accepted frame_start; 0 means no symbols
- s_re  input  16  data subcarrier real, signed
- s_im  input  16  data subcarrier imaginary, signed
- s_valid  input  1  data subcarrier valid
- s_ready  output  1  data subcarrier accepted when s_valid && s_ready
- ifft_re  output  16  IFFT input real (drives IFFT in_re)
- ifft_im  output  16  IFFT input imaginary (drives IFFT in_im)
- ifft_valid  output  1  drives IFFT in_valid
- ifft_ready  input  1  from IFFT in_ready
- ifft_last  output  1  high with bin 63 of each symbol
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the last bin of the frame is accepted by the IFFT

Behaviour:
- Reset (async, rst=1): state IDLE, bin_cnt=0, sym_cnt=0, LFSR=7'h7F.
- Reset values of outputs: ifft_valid=0, ifft_re=0, ifft_im=0, ifft_last=0, s_ready=0, busy=0, frame_done=0.
- Reset mid-frame aborts immediately; no partial symbol is resumed.
- States:
  - IDLE: on frame_start, go to RUN if frame_len≠0.
    - On entry to RUN: sym_cnt=frame_len, bin_cnt=0, LFSR=7'h7F.
    - If frame_len=0: stay IDLE and pulse frame_done next cycle.
  - RUN: busy=1. Returns to IDLE when the bin 63 handshake of the final symbol occurs.
- Bin map (index = IFFT bin):
  - Null bins output 0+j0: 0 and 27..37.
  - Pilot bins: 7, 21, 43, 57.
  - Data bins: all others (48), consumed in ascending bin order.
- Pilot value: real = p × c × PILOT_AMP, imag = 0.
  - c = +1 for bins 7, 43, 57; c = −1 for bin 21.
  - p = +1 if LFSR bit b=0, −1 if b=1, where b = LFSR[6]^LFSR[3].
- LFSR update: after bin 63 of each symbol is accepted, LFSR ← {LFSR[5:0], b}.
  - Resulting polarity sequence starts +1,+1,+1,+1,−1,−1,−1,+1.
- Output stage: a single registered stage.
  - load = RUN && (!ifft_valid || ifft_ready) && (current bin is not data || s_valid).
  - s_ready = RUN && (!ifft_valid || ifft_ready) && current bin is data. It is combinational from ifft_ready/ifft_valid/state.
  - On load: ifft_re/ifft_im/ifft_last register the bin value; ifft_valid ← 1; bin_cnt increments, wrapping 63→0.
  - If ifft_ready && !load: ifft_valid ← 0.
  - Latency: 1 cycle from s handshake to ifft_valid.
  - Full throughput: 64 bins in 64 cycles when s_valid and ifft_ready are held high.
- Null/pilot bins never stall on s_valid. Data bins stall with ifft_valid held/cleared per the rule above. Output data stays stable while ifft_valid && !ifft_ready.
- sym_cnt decrements when bin 63 is loaded. Once the last symbol's bin 63 is loaded, no further loads occur.
  - frame_done pulses on the cycle after that bin's IFFT handshake; busy drops the same cycle.
- frame_start while busy: ignored, with no effect on the counters.
- Data received while IDLE: s_ready=0, so nothing is consumed.

Test Plan:
- Reset then frame_start with frame_len=1; s supplies re=k, im=−k for k=1..48; ifft_ready=1 -> 64 outputs.
  - Bins 0 and 27..37 are 0; bin 1 = (1,−1); bin 6 = 6; bin 8 = 7.
  - Bin 7 real = +8192, bin 21 real = −8192; bins 43/57 = +8192.
  - ifft_last only at bin 63; frame_done one cycle after; busy 0.
- frame_len=8, continuous data -> pilot bin 7 real across symbols = +8192 ×4, then −8192 ×3, then +8192.
  - 512 consecutive valid cycles, no bubbles.
- ifft_ready toggling 1,0,0,1 pattern -> no bin lost or duplicated; ifft_re/im/last stable while stalled; s consumed exactly 48 per symbol.
- s_valid low during bins 1..6 -> ifft_valid deasserts; on s_valid return, output resumes at bin 1.
  - Separately, s_valid low at bin 7 -> pilots and nulls still emitted without waiting.
- frame_start asserted mid-frame -> ignored; frame_len=0 -> frame_done pulse, busy stays 0, s_ready stays 0.
- rst asserted at bin 30 of symbol 2 -> all outputs 0 immediately.
  - A following frame starts at bin 0 with pilot polarity +1.
